memory_cycle_bist: RTL and testbench

- MEM pipeline stage, directly downstream of the execute stage. Consumes the EX/MEM register outputs and holds the data memory array.
- Drives the MEM/WB pipeline register.
- Adds a destructive March C- memory BIST with single-word spare repair.
- Test is triggered externally (boot / maintenance). The pipeline is held via stall_out while the test runs.

---
 rtl/memory_cycle_bist.sv | 227 ++++++++++++++++++++++
 tb/tb_memory_cycle_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_bist.sv
// MEM pipeline stage: data memory array, MEM/WB register and a March C- BIST
// that can remap a single faulty word onto a spare register.
module memory_cycle_bist #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [31:0]       PCPlus4M,
    input  logic [31:0]       WriteDataM,
    input  logic [31:0]       ALU_ResultM,
    input  logic              test_en_in,
    input  logic [1:0]        inject_en,
    input  logic [ADDR_W-1:0] inject_addr_0,
    input  logic [ADDR_W-1:0] inject_addr_1,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [31:0]       PCPlus4W,
    output logic [31:0]       ALU_ResultW,
    output logic [31:0]       ReadDataW,
    output logic              stall_out,
    output logic              bist_done,
    output logic              bist_fail,
    output logic              repair_active,
    output logic [ADDR_W-1:0] repair_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_UR0W1, S_UR1W0, S_DR0W1, S_DR1W0, S_R0, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] bist_addr;
    logic              bist_sub;
    logic [1:0]        fault_cnt;
    logic [31:0]       spare;
    logic [31:0]       mem [DEPTH];

    logic              two_op, desc, bist_rd, bist_we;
    logic [31:0]       bist_expect, bist_wdata;
    logic [ADDR_W-1:0] pipe_idx;
    logic              pipe_active, spare_hit, entry, mismatch;
    logic [31:0]       pipe_rdata, bist_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    assign pipe_idx    = ALU_ResultM[ADDR_W+1:2];
    assign pipe_active = !stall_out;
    assign spare_hit   = repair_active && (pipe_idx == repair_addr);
    assign entry       = (state == S_IDLE) && (next_state == S_W0);
    assign mismatch    = bist_rd && (bist_rdata != bist_expect);

    // Stuck-at-1 injection applies to the array on both ports; the spare bypasses it
    always_comb begin
        pipe_rdata = mem[pipe_idx];
        bist_rdata = mem[bist_addr];
        if ((inject_en[0] && pipe_idx == inject_addr_0) ||
            (inject_en[1] && pipe_idx == inject_addr_1))
            pipe_rdata[0] = 1'b1;
        if ((inject_en[0] && bist_addr == inject_addr_0) ||
            (inject_en[1] && bist_addr == inject_addr_1))
            bist_rdata[0] = 1'b1;
        if (spare_hit)
            pipe_rdata = spare;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = pipe_idx;
        mem_wdata = WriteDataM;
        if (bist_we) begin
            mem_we    = 1'b1;
            mem_waddr = bist_addr;
            mem_wdata = bist_wdata;
        end else if (pipe_active && MemWriteM && !spare_hit) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state  = state;
        stall_out   = 1'b0;
        bist_done   = 1'b0;
        two_op      = 1'b0;
        desc        = 1'b0;
        bist_rd     = 1'b0;
        bist_we     = 1'b0;
        bist_expect = '0;
        bist_wdata  = '0;
        case (state)
            S_IDLE: if (test_en_in) next_state = S_W0;
            S_W0: begin
                stall_out = 1'b1;
                bist_we   = 1'b1;
                if (bist_addr == LAST_ADDR) next_state = S_UR0W1;
            end
            S_UR0W1: begin
                stall_out = 1'b1;
                two_op    = 1'b1;
                if (bist_sub && bist_addr == LAST_ADDR) next_state = S_UR1W0;
            end
            S_UR1W0: begin
                stall_out   = 1'b1;
                two_op      = 1'b1;
                bist_expect = '1;
                if (bist_sub && bist_addr == LAST_ADDR) next_state = S_DR0W1;
            end
            S_DR0W1: begin
                stall_out = 1'b1;
                two_op    = 1'b1;
                desc      = 1'b1;
                if (bist_sub && bist_addr == '0) next_state = S_DR1W0;
            end
            S_DR1W0: begin
                stall_out   = 1'b1;
                two_op      = 1'b1;
                desc        = 1'b1;
                bist_expect = '1;
                if (bist_sub && bist_addr == '0) next_state = S_R0;
            end
            S_R0: begin
                stall_out = 1'b1;
                bist_rd   = 1'b1;
                if (bist_addr == LAST_ADDR) next_state = S_DONE;
            end
            S_DONE: begin
                bist_done  = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Two-op elements read the current background, then write its complement
        if (two_op) begin
            bist_rd    = !bist_sub;
            bist_we    = bist_sub;
            bist_wdata = ~bist_expect;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bist_addr <= '0;
            bist_sub  <= 1'b0;
        end else if (next_state != state) begin
            bist_addr <= (next_state == S_DR0W1 || next_state == S_DR1W0) ? LAST_ADDR : '0;
            bist_sub  <= 1'b0;
        end else if (state == S_W0 || state == S_R0) begin
            bist_addr <= bist_addr + 1'b1;
        end else if (two_op) begin
            bist_sub <= !bist_sub;
            if (bist_sub)
                bist_addr <= desc ? bist_addr - 1'b1 : bist_addr + 1'b1;
        end
    end

    // Fault count saturates at 2: only distinctness from the first faulty word matters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_cnt     <= '0;
            bist_fail     <= 1'b0;
            repair_active <= 1'b0;
            repair_addr   <= '0;
            spare         <= '0;
        end else begin
            if (entry) begin
                fault_cnt     <= '0;
                bist_fail     <= 1'b0;
                repair_active <= 1'b0;
            end else if (mismatch) begin
                if (fault_cnt == 2'd0) begin
                    repair_addr <= bist_addr;
                    fault_cnt   <= 2'd1;
                end else if (bist_addr != repair_addr) begin
                    fault_cnt <= 2'd2;
                end
            end else if (state == S_DONE) begin
                if (fault_cnt == 2'd1) begin
                    repair_active <= 1'b1;
                end else if (fault_cnt == 2'd2) begin
                    bist_fail     <= 1'b1;
                    repair_active <= 1'b0;
                end
            end
            if (state == S_DONE && fault_cnt == 2'd1)
                spare <= '0;
            else if (pipe_active && MemWriteM && spare_hit)
                spare <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
        end else begin
            RegWriteW   <= RegWriteM && pipe_active;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= pipe_rdata;
        end
    end

endmodule

// File: tb/tb_memory_cycle_bist.sv
// Self-checking bench for memory_cycle_bist: table-driven load/store vectors
// followed by directed BIST, repair, fault and reset-abort sequences.
module tb_memory_cycle_bist;

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        test_en_in;
    logic [1:0]  inject_en;
    logic [5:0]  inject_addr_0, inject_addr_1;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        stall_out, bist_done, bist_fail, repair_active;
    logic [5:0]  repair_addr;

    int checks = 0;
    int failures = 0;

    memory_cycle_bist #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM), .test_en_in(test_en_in), .inject_en(inject_en),
        .inject_addr_0(inject_addr_0), .inject_addr_1(inject_addr_1),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .stall_out(stall_out), .bist_done(bist_done), .bist_fail(bist_fail),
        .repair_active(repair_active), .repair_addr(repair_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RegWriteM   = v.reg_write;
        MemWriteM   = v.mem_write;
        ResultSrcM  = v.result_src;
        RD_M        = v.rd;
        PCPlus4M    = v.pc4;
        WriteDataM  = v.wdata;
        ALU_ResultM = v.alu;
        tick();
    endtask

    task automatic idleInputs();
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = '0;
        PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0; test_en_in = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        RegWriteM = 1'b0; MemWriteM = 1'b1; ALU_ResultM = addr; WriteDataM = data;
        tick();
        MemWriteM = 1'b0;
    endtask

    task automatic loadCheck(input string name, input logic [31:0] addr,
                             input logic [31:0] expected);
        RegWriteM = 1'b1; MemWriteM = 1'b0; ALU_ResultM = addr;
        tick();
        checkOutput(name, ReadDataW, expected);
        checkOutput({name, "_regwrite"}, {31'b0, RegWriteW}, 32'd1);
        RegWriteM = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic runBist(input string tag, input logic exp_fail, input logic exp_repair,
                           input logic [5:0] exp_addr, input bit with_noise);
        int   stall_cycles;
        int   done_pulses;
        int   rw_viol;
        logic prev_stall;
        stall_cycles = 0;
        done_pulses  = 0;
        rw_viol      = 0;
        prev_stall   = 1'b0;
        test_en_in   = 1'b1;
        RegWriteM    = 1'b1;
        if (with_noise) begin
            MemWriteM   = 1'b1;
            ALU_ResultM = 32'h20;
            WriteDataM  = 32'h1234_5678;
        end
        tick();
        test_en_in = 1'b0;
        for (int c = 0; c < 660; c++) begin
            if (stall_out) stall_cycles++;
            if (bist_done) done_pulses++;
            if (prev_stall && RegWriteW) rw_viol++;
            prev_stall = stall_out;
            if (with_noise && c == 100) test_en_in = 1'b1;
            if (with_noise && c == 101) test_en_in = 1'b0;
            if (!stall_out) MemWriteM = 1'b0;
            tick();
        end
        RegWriteM = 1'b0;
        MemWriteM = 1'b0;
        tick();
        checkOutput({tag, "_stall_cycles"}, stall_cycles, 32'd640);
        checkOutput({tag, "_done_pulses"}, done_pulses, 32'd1);
        checkOutput({tag, "_bubble_violations"}, rw_viol, 32'd0);
        checkOutput({tag, "_bist_fail"}, {31'b0, bist_fail}, {31'b0, exp_fail});
        checkOutput({tag, "_repair_active"}, {31'b0, repair_active}, {31'b0, exp_repair});
        if (exp_repair)
            checkOutput({tag, "_repair_addr"}, {26'b0, repair_addr}, {26'b0, exp_addr});
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h100, 32'hDEAD_BEEF, 32'h010, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h104, 32'h0,         32'h010, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd6,  32'h108, 32'h0,         32'h110, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd7,  32'h10C, 32'h0,         32'h013, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h110, 32'hCAFE_F00D, 32'h004, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd8,  32'h114, 32'h0,         32'h104, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h118, 32'h0,         32'h010, 1'b1, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h11C, 32'h1234_5678, 32'h0FC, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'h120, 32'h0,         32'h1FC, 1'b1, 32'h1234_5678};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 5'd3,  32'h124, 32'h0,         32'h004, 1'b1, 32'hCAFE_F00D};

        rst = 1'b0;
        inject_en = 2'b00; inject_addr_0 = '0; inject_addr_1 = '0;
        idleInputs();
        RegWriteM = 1'b1; PCPlus4M = 32'h1234; ALU_ResultM = 32'h44; RD_M = 5'd7;
        tick();
        tick();
        checkOutput("reset_regwrite", {31'b0, RegWriteW}, 32'd0);
        checkOutput("reset_pcplus4", PCPlus4W, 32'd0);
        checkOutput("reset_alu", ALU_ResultW, 32'd0);
        checkOutput("reset_rd", {27'b0, RD_W}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall_out}, 32'd0);
        checkOutput("reset_done", {31'b0, bist_done}, 32'd0);
        checkOutput("reset_fail", {31'b0, bist_fail}, 32'd0);
        checkOutput("reset_repair", {31'b0, repair_active}, 32'd0);
        idleInputs();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_regwrite", i), {31'b0, RegWriteW}, {31'b0, vecs[i].reg_write});
            checkOutput($sformatf("vec%0d_resultsrc", i), {31'b0, ResultSrcW}, {31'b0, vecs[i].result_src});
            checkOutput($sformatf("vec%0d_rd", i), {27'b0, RD_W}, {27'b0, vecs[i].rd});
            checkOutput($sformatf("vec%0d_pcplus4", i), PCPlus4W, vecs[i].pc4);
            checkOutput($sformatf("vec%0d_alu", i), ALU_ResultW, vecs[i].alu);
            if (vecs[i].chk_rdata)
                checkOutput($sformatf("vec%0d_readdata", i), ReadDataW, vecs[i].exp_rdata);
        end
        idleInputs();
        tick();

        runBist("clean_noise", 1'b0, 1'b0, 6'd0, 1'b1);

        inject_en = 2'b01; inject_addr_0 = 6'd5;
        runBist("single_fault", 1'b0, 1'b1, 6'd5, 1'b0);
        store(32'h14, 32'h0);
        loadCheck("spare_zero", 32'h14, 32'h0);
        store(32'h14, 32'hA5A5_A5A4);
        loadCheck("spare_pattern", 32'h14, 32'hA5A5_A5A4);
        store(32'h18, 32'h0);
        loadCheck("neighbour_word", 32'h18, 32'h0);

        pulseReset();
        checkOutput("post_reset_repair", {31'b0, repair_active}, 32'd0);
        checkOutput("post_reset_repair_addr", {26'b0, repair_addr}, 32'd0);
        store(32'h14, 32'h0);
        loadCheck("unrepaired_stuck_bit", 32'h14, 32'h1);

        inject_en = 2'b11; inject_addr_0 = 6'd5; inject_addr_1 = 6'd9;
        runBist("two_faults", 1'b1, 1'b0, 6'd0, 1'b0);

        inject_addr_1 = 6'd5;
        runBist("same_fault_twice", 1'b0, 1'b1, 6'd5, 1'b0);

        test_en_in = 1'b1;
        tick();
        test_en_in = 1'b0;
        repeat (300) tick();
        checkOutput("abort_pre_stall", {31'b0, stall_out}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_stall", {31'b0, stall_out}, 32'd0);
        checkOutput("abort_done", {31'b0, bist_done}, 32'd0);
        checkOutput("abort_repair", {31'b0, repair_active}, 32'd0);
        checkOutput("abort_repair_addr", {26'b0, repair_addr}, 32'd0);
        checkOutput("abort_fail", {31'b0, bist_fail}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        inject_en = 2'b00;
        tick();
        checkOutput("abort_idle", {31'b0, stall_out}, 32'd0);
        runBist("restart", 1'b0, 1'b0, 6'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
